// File: rtl/spi_ram_ctrl_pkg.sv
// Shared constants and state encoding for the SPI RAM controller.
package spi_ram_pkg;

    localparam int unsigned CMD_BITS  = 8;
    localparam int unsigned ADDR_BITS = 16;

    localparam logic [CMD_BITS-1:0] CMD_READ  = 8'h03;
    localparam logic [CMD_BITS-1:0] CMD_WRITE = 8'h02;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        DESEL_LO = 2'd2,
        DESEL_HI = 2'd3
    } state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// CPU-side request/response port of the SPI RAM controller.
interface spi_ram_ctrl_if
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 2
);
    logic                    start;
    logic                    we;
    logic [ADDR_BITS-1:0]    addr;
    logic [8*DATA_BYTES-1:0] wdata;
    logic                    busy;
    logic                    done;
    logic [8*DATA_BYTES-1:0] rdata;

    modport master (
        output start, we, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, we, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// SPI mode-0 master turning single-word CPU requests into 03h/02h SPI RAM frames.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_ram_ctrl_if.slave bus,
    output logic          spi_clk_o,
    output logic          spi_select_o,
    output logic          spi_mosi_o,
    input  logic          spi_miso_i
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned NB = CMD_BITS + ADDR_BITS + DW;
    localparam int unsigned CW = $clog2(2 * NB);
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * NB - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NB-1:0]   sr_q, sr_d;
    logic            we_q, we_d;
    logic            real_q, real_d;
    logic            sclk_q, sclk_d;
    logic            sel_q, sel_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NB-1:0]   frame;
    logic [NB-1:0]   shifted;
    logic [DW-1:0]   rx_word;

    // Outgoing frame: command, address high/low, then data bytes LSB-byte first (zeros on reads).
    always_comb begin
        frame = '0;
        frame[NB-1 -: CMD_BITS] = bus.we ? CMD_WRITE : CMD_READ;
        frame[NB-1-CMD_BITS -: ADDR_BITS] = bus.addr;
        if (bus.we) begin
            for (int k = 0; k < int'(DATA_BYTES); k++) begin
                frame[DW-1-8*k -: 8] = bus.wdata[8*k +: 8];
            end
        end
    end

    // Received bytes arrive first-byte-first in the low DW bits; byte k lands in rdata[8k+7:8k].
    always_comb begin
        rx_word = '0;
        for (int k = 0; k < int'(DATA_BYTES); k++) begin
            rx_word[8*k +: 8] = sr_q[DW-1-8*k -: 8];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        we_d    = we_q;
        real_d  = real_q;
        sclk_d  = 1'b0;
        sel_d   = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        shifted = {sr_q[NB-2:0], spi_miso_i};

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sr_d    = frame;
                    we_d    = bus.we;
                    real_d  = 1'b1;
                    sel_d   = 1'b0;
                    mosi_d  = frame[NB-1];
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                sel_d = 1'b0;
                cnt_d = cnt_q + CW'(1);
                if (!cnt_q[0]) begin
                    sclk_d = 1'b1;
                    mosi_d = sr_q[NB-1];
                end else begin
                    sr_d = shifted;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DESEL_LO;
                        sel_d   = 1'b1;
                    end else begin
                        mosi_d = shifted[NB-1];
                    end
                end
            end
            DESEL_LO: begin
                state_d = DESEL_HI;
                sclk_d  = 1'b1;
            end
            DESEL_HI: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = real_q;
                real_d  = 1'b0;
                if (real_q && !we_q) begin
                    rdata_d = rx_word;
                end
            end
            default: state_d = DESEL_LO;
        endcase
    end

    // State and output registers; reset lands in DESEL_LO to flush the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DESEL_LO;
            cnt_q   <= '0;
            sr_q    <= '0;
            we_q    <= 1'b0;
            real_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sel_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            we_q    <= we_d;
            real_q  <= real_d;
            sclk_q  <= sclk_d;
            sel_q   <= sel_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign spi_clk_o    = sclk_q;
    assign spi_select_o = sel_q;
    assign spi_mosi_o   = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;

endmodule
